// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    localparam logic [3:0] CNT_MID  = 4'(MID_SAMPLE);
    localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_sync_bit.sv
// N-stage single-bit synchroniser for asynchronous inputs, with a selectable reset level.
module uart_sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART receiver: 16x-oversampled deserialiser with a valid/ready holding register.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle, waiting for a falling edge on rx_s
// ST_START  | counting to the start-bit centre to reject glitches
// ST_DATA   | sampling data bits at each bit centre, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling the stop bit; frame completes here
// ST_BREAK  | stop bit was 0; wait for the line to return high
module uart_rx_oversampler
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int              IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_t          state;
    logic [3:0]           cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] data_sr;
    logic                 par_bit;
    logic                 rx_s;
    logic                 frame_done;
    logic                 par_err_new;

    uart_sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            data_sr <= '0;
            par_bit <= 1'b0;
        end else if (baud_tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        data_sr[idx] <= rx_s;
                        cnt          <= '0;
                        if (idx == IDX_LAST) begin
                            state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        par_bit <= rx_s;
                        cnt     <= '0;
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state != ST_IDLE);
    assign frame_done  = (state == ST_STOP) && baud_tick && (cnt == CNT_LAST);
    assign par_err_new = (PARITY_EN != 0) && ((^data_sr) ^ par_bit ^ (PARITY_ODD != 0));

    // A completed frame may load in the same cycle the held one is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= data_sr;
                    frame_err  <= ~rx_s;
                    parity_err <= par_err_new;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
